id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/immediate width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port flush  input  1  drop all buffered instructions.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_inst input 32 (raw RV32I word), in_pc input XLEN.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, out_pc output XLEN.
REQ-007 SHALL have ports out_ex_code output ExCode, out_alu_op output aluop, out_rs1/out_rs2/out_rd output 5 each, out_imm output XLEN (sign-extended), out_unsup output 1.

Function
REQ-008 SHALL transfer on in_valid&in_ready (input) and out_valid&out_ready (output); a valid beat and its fields SHALL hold stable until transferred.
REQ-009 SHALL decode combinationally from in_inst and register the result; latency 1 cycle from input transfer to out_valid with an empty buffer.
REQ-010 SHALL map I-ALU (0010011), R (0110011), load (0000011), store (0100011), branch (1100011) funct3/funct7 to the matching ExCode; SRLI and SRAI both map to SRI, with imm[10]=inst[30] distinguishing them.
REQ-011 SHALL map alu_op: alu_add for ADDI/ADD/loads/stores; alu_sub for SUB; alu_eq for BEQ/BNE; alu_ge_s for SLT/SLTI/BLT/BGE; alu_ge_u for SLTU/SLTIU/BLTU/BGEU; alu_nop otherwise.
REQ-012 SHALL form out_imm per I/S/B format (B bit0=0), sign-extended from bit 31; R-type imm=0.
REQ-013 SHALL pass out_rs1/out_rs2/out_rd from inst fields; fields not used by the format SHALL be 0.
REQ-014 SHALL output ex_code NOP, alu_nop, out_unsup=1 for any other opcode or undefined funct3/funct7 (LUI, AUIPC, JAL, JALR, FENCE, SYSTEM included); the beat still transfers.
REQ-015 SHALL buffer in a 2-entry skid: states EMPTY, ONE, TWO; in_ready SHALL be a register, 1 in EMPTY/ONE, 0 in TWO.
REQ-016 Transitions: EMPTY-in->ONE; ONE-in-only->TWO; ONE-out-only->EMPTY; ONE in&out->ONE; TWO-out->ONE (skid entry becomes head); no other change.
REQ-017 SHALL preserve program order; skid entry is never output before the head entry.
REQ-018 With out_ready held 1 and in_valid held 1, SHALL sustain one instruction per cycle.
REQ-019 flush SHALL force EMPTY next cycle: out_valid=0, in_ready=1; an input handshake in the flush cycle is discarded; flush outranks all other events.

Reset
REQ-020 On rst_n=0 at a clock edge, state SHALL become EMPTY: out_valid=0, in_ready=1, out_ex_code=NOP, out_alu_op=alu_nop, out_rs1/rs2/rd=0, out_imm=0, out_pc=0, out_unsup=0.
REQ-021 Reset mid-operation SHALL discard buffered beats; reset outranks flush.

Structure
REQ-022 ExCode and aluop SHALL come from the shared opcode package; opcode field constants (7-bit major opcodes) and the buffer state enum SHALL be added to the shared package.
REQ-023 Decode logic SHALL be one combinational sub-module rv32i_decoder; id_stage holds only the skid buffer and control.

Verification
REQ-024 in_inst=0x00500093 (ADDI x1,x0,5), in_pc=0x100 -> next cycle out_valid=1, ADDI, alu_add, rd=1, rs1=0, imm=5, pc=0x100.
REQ-025 in_inst=0x4030D113 (SRAI x2,x1,3) -> SRI, rs1=1, rd=2, imm=0x00000403.
REQ-026 in_inst=0xFE208EE3 (BEQ x1,x2,-4) -> BEQ, alu_eq, rs1=1, rs2=2, imm=0xFFFFFFFC, rd=0.
REQ-027 out_ready=0, three back-to-back beats -> two accepted, in_ready=0 from cycle after second; out_ready=1 -> all three emerge in order, no loss or duplication.
REQ-028 State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; neither buffered nor flush-cycle beat ever appears.
REQ-029 in_inst=0x00000037 (LUI) -> NOP, alu_nop, out_unsup=1; rst_n=0 while in state TWO -> all outputs at REQ-020 values next cycle.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode types for the ID stage: execution codes, ALU ops,
// major opcode constants, immediate formats and the skid-buffer state.
package id_stage_pkg;

    localparam int unsigned XLEN_W = 32;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [5:0] {
        NOP,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU
    } ExCode;

    typedef enum logic [2:0] {
        alu_nop,
        alu_add,
        alu_sub,
        alu_eq,
        alu_ge_s,
        alu_ge_u
    } aluop;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_R
    } fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_e;

    // One decoded instruction as held in the skid buffer.
    typedef struct packed {
        ExCode              ex_code;
        aluop               alu_op;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [XLEN_W-1:0]  imm;
        logic               unsup;
        logic [XLEN_W-1:0]  pc;
    } dec_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder for ALU, load, store and branch groups.
// In: inst (32b). Out: ex_code, alu_op, rs1/rs2/rd, imm (sign-ext), unsup.
module rv32i_decoder
    import id_stage_pkg::*;
(
    input  logic [31:0] inst,
    output ExCode       ex_code,
    output aluop        alu_op,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        unsup
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    fmt_e       fmt_eff;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        ex_code = NOP;
        fmt     = FMT_NONE;
        unique case (opcode)
            OPC_OP_IMM: begin
                fmt = FMT_I;
                case (funct3)
                    3'b000: ex_code = ADDI;
                    3'b010: ex_code = SLTI;
                    3'b011: ex_code = SLTIU;
                    3'b100: ex_code = XORI;
                    3'b110: ex_code = ORI;
                    3'b111: ex_code = ANDI;
                    3'b001: if (funct7 == F7_BASE) ex_code = SLLI;
                    // SRLI/SRAI share one code; imm[10] tells them apart.
                    3'b101: if (funct7 == F7_BASE || funct7 == F7_ALT)
                                ex_code = SRI;
                    default: ex_code = NOP;
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ex_code = ADD;
                        3'b001:  ex_code = SLL;
                        3'b010:  ex_code = SLT;
                        3'b011:  ex_code = SLTU;
                        3'b100:  ex_code = XOR;
                        3'b101:  ex_code = SRL;
                        3'b110:  ex_code = OR;
                        default: ex_code = AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  ex_code = SUB;
                        3'b101:  ex_code = SRA;
                        default: ex_code = NOP;
                    endcase
                end
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (funct3)
                    3'b000:  ex_code = LB;
                    3'b001:  ex_code = LH;
                    3'b010:  ex_code = LW;
                    3'b100:  ex_code = LBU;
                    3'b101:  ex_code = LHU;
                    default: ex_code = NOP;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (funct3)
                    3'b000:  ex_code = SB;
                    3'b001:  ex_code = SH;
                    3'b010:  ex_code = SW;
                    default: ex_code = NOP;
                endcase
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (funct3)
                    3'b000:  ex_code = BEQ;
                    3'b001:  ex_code = BNE;
                    3'b100:  ex_code = BLT;
                    3'b101:  ex_code = BGE;
                    3'b110:  ex_code = BLTU;
                    3'b111:  ex_code = BGEU;
                    default: ex_code = NOP;
                endcase
            end
            default: ex_code = NOP;
        endcase
    end

    // Anything undecodable carries no operand fields at all.
    assign fmt_eff = (ex_code == NOP) ? FMT_NONE : fmt;
    assign unsup   = (ex_code == NOP);

    always_comb begin
        rs1 = '0;
        rs2 = '0;
        rd  = '0;
        imm = '0;
        case (fmt_eff)
            FMT_I: begin
                rs1 = inst[19:15];
                rd  = inst[11:7];
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            FMT_S: begin
                rs1 = inst[19:15];
                rs2 = inst[24:20];
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            FMT_B: begin
                rs1 = inst[19:15];
                rs2 = inst[24:20];
                imm = {{19{inst[31]}}, inst[31], inst[7],
                       inst[30:25], inst[11:8], 1'b0};
            end
            FMT_R: begin
                rs1 = inst[19:15];
                rs2 = inst[24:20];
                rd  = inst[11:7];
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_op = alu_nop;
        case (ex_code)
            ADDI, ADD,
            LB, LH, LW, LBU, LHU,
            SB, SH, SW:               alu_op = alu_add;
            SUB:                      alu_op = alu_sub;
            BEQ, BNE:                 alu_op = alu_eq;
            SLT, SLTI, BLT, BGE:      alu_op = alu_ge_s;
            SLTU, SLTIU, BLTU, BGEU:  alu_op = alu_ge_u;
            default:                  alu_op = alu_nop;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// ID stage: decodes each accepted instruction and holds it in a 2-entry
// skid buffer. In: clk, rst_n (sync), flush, in_valid/in_inst/in_pc.
// Out: in_ready (registered), out_valid + decoded fields of the head entry.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output ExCode           out_ex_code,
    output aluop            out_alu_op,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_unsup
);

    ExCode       dec_ex_code;
    aluop        dec_alu_op;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_unsup;
    dec_t        dec_in;

    buf_state_e state_q, state_d;
    dec_t       head_q, head_d;
    dec_t       skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic       in_fire;
    logic       out_fire;

    rv32i_decoder u_dec (
        .inst    (in_inst),
        .ex_code (dec_ex_code),
        .alu_op  (dec_alu_op),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .imm     (dec_imm),
        .unsup   (dec_unsup)
    );

    always_comb begin
        dec_in         = '0;
        dec_in.ex_code = dec_ex_code;
        dec_in.alu_op  = dec_alu_op;
        dec_in.rs1     = dec_rs1;
        dec_in.rs2     = dec_rs2;
        dec_in.rd      = dec_rd;
        dec_in.imm     = dec_imm;
        dec_in.unsup   = dec_unsup;
        dec_in.pc      = in_pc;
    end

    assign out_valid = (state_q != BUF_EMPTY);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        head_d  = dec_in;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = dec_in;
                    end else if (in_fire) begin
                        skid_d  = dec_in;
                        state_d = BUF_TWO;
                    end else if (out_fire) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // Skid entry is promoted so order is preserved.
                    if (out_fire) begin
                        head_d  = skid_q;
                        state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
        in_ready_d = (state_d != BUF_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign out_pc      = head_q.pc;
    assign out_ex_code = head_q.ex_code;
    assign out_alu_op  = head_q.alu_op;
    assign out_rs1     = head_q.rs1;
    assign out_rs2     = head_q.rs2;
    assign out_rd      = head_q.rd;
    assign out_imm     = head_q.imm;
    assign out_unsup   = head_q.unsup;

endmodule
